// File: rtl/plab3_mem_prefetch_refill_queue.sv
// plab3_mem_prefetch_refill_queue
//   Sits between the prefetch buffer's memory port and main memory. Line refill requests are
//   queued in a small FIFO and issued to memory while the number of un-answered requests stays
//   below p_max_outstanding. Responses pass straight through, in order, back to the buffer.
//   When the security domain changes, new requests are refused until every queued and in-flight
//   request of the old domain has completed.
//
// Ports
//   clk, reset (async, active-low)     clock / reset
//   domain                             current security domain
//   pfreq_msg/val/rdy                  refill requests from the prefetch buffer
//   pfresp_msg/val/rdy                 responses back to the prefetch buffer
//   memreq_msg/val/rdy                 requests to main memory
//   memresp_msg/val/rdy                responses from main memory
//   busy                               queue, in-flight traffic or a domain drain pending
//
// Optional feature
//   PLAB3_MEM_PF_REFILL_BYPASS_EN: when the FIFO is empty and issue is allowed, a request goes
//   straight to memreq in the same cycle (introduces a combinational pfreq_rdy <- memreq_rdy path).
module plab3_mem_prefetch_refill_queue #(
  parameter int unsigned p_opaque_nbits    = 8,
  parameter int unsigned p_num_entries     = 4,
  parameter int unsigned p_max_outstanding = 2,
  parameter int unsigned abw               = 32,
  parameter int unsigned clw               = 128,
  // Memory message layouts: {type, opaque, addr, len, data} and {type, opaque, test, len, data}
  localparam int unsigned ReqNbits  = 3 + p_opaque_nbits + abw + $clog2(clw / 8) + clw,
  localparam int unsigned RespNbits = 3 + p_opaque_nbits + 2 + $clog2(clw / 8) + clw
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 domain,
  input  logic [ReqNbits-1:0]  pfreq_msg,
  input  logic                 pfreq_val,
  output logic                 pfreq_rdy,
  output logic [RespNbits-1:0] pfresp_msg,
  output logic                 pfresp_val,
  input  logic                 pfresp_rdy,
  output logic [ReqNbits-1:0]  memreq_msg,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,
  input  logic [RespNbits-1:0] memresp_msg,
  input  logic                 memresp_val,
  output logic                 memresp_rdy,
  output logic                 busy
);

  localparam int unsigned PtrW = $clog2(p_num_entries);
  localparam int unsigned CntW = $clog2(p_num_entries + 1);
  localparam int unsigned OutW = $clog2(p_max_outstanding + 1);

  localparam logic [1:0] StResetWait = 2'd0;
  localparam logic [1:0] StActive    = 2'd1;
  localparam logic [1:0] StDrain     = 2'd2;

  logic [1:0]          state_q, state_d;
  logic                domain_q, domain_d;
  logic [ReqNbits-1:0] mem_q [p_num_entries];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [OutW-1:0]     out_cnt_q, out_cnt_d;

  logic fifo_empty, fifo_full, can_issue, active, resp_open, bypass;
  logic pfreq_fire, memreq_fire, memresp_fire, enq, deq;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(p_num_entries));
  assign can_issue  = (out_cnt_q < OutW'(p_max_outstanding));
  assign active     = (state_q == StActive);
  assign resp_open  = (state_q != StResetWait);

`ifdef PLAB3_MEM_PF_REFILL_BYPASS_EN
  assign bypass = active && fifo_empty && can_issue;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    memreq_val = bypass ? pfreq_val : (!fifo_empty && can_issue);
    memreq_msg = '0;
    if (memreq_val) begin
      memreq_msg = bypass ? pfreq_msg : mem_q[rd_ptr_q];
    end
    // bypass is constant 0 unless the feature is built in, so no comb path exists by default
    pfreq_rdy   = active && (!fifo_full || (bypass && memreq_rdy));
    pfresp_val  = resp_open && memresp_val;
    pfresp_msg  = resp_open ? memresp_msg : '0;
    memresp_rdy = resp_open && pfresp_rdy;
    busy        = !fifo_empty || (out_cnt_q != '0) || (state_q == StDrain);
  end

  assign pfreq_fire   = pfreq_val && pfreq_rdy;
  assign memreq_fire  = memreq_val && memreq_rdy;
  assign memresp_fire = memresp_val && memresp_rdy;
  // A bypassed request goes straight out and never occupies a FIFO slot
  assign enq          = pfreq_fire && !(bypass && memreq_fire);
  assign deq          = memreq_fire && !bypass;

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (memreq_fire && !memresp_fire) begin
      out_cnt_d = out_cnt_q + OutW'(1);
    end else if (!memreq_fire && memresp_fire && (out_cnt_q != '0)) begin
      // A response with nothing outstanding is passed through but must not underflow
      out_cnt_d = out_cnt_q - OutW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    domain_d = domain_q;
    case (state_q)
      StResetWait: begin
        state_d  = StActive;
        domain_d = domain;
      end
      StActive: begin
        if (domain != domain_q) state_d = StDrain;
      end
      StDrain: begin
        if (fifo_empty && (out_cnt_q == '0) && !memresp_fire) begin
          state_d  = StActive;
          domain_d = domain;
        end
      end
      default: state_d = StResetWait;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StResetWait;
      domain_q  <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      domain_q  <= domain_d;
      out_cnt_q <= out_cnt_d;
      if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (enq && !deq) begin
        count_q <= count_q + CntW'(1);
      end else if (!enq && deq) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= pfreq_msg;
  end

endmodule

// File: tb/tb_plab3_mem_prefetch_refill_queue.sv
module tb_plab3_mem_prefetch_refill_queue;

  localparam int ReqW  = 3 + 8 + 32 + 4 + 128;
  localparam int RespW = 3 + 8 + 2 + 4 + 128;

  logic             clk = 1'b0;
  logic             reset;
  logic             domain;
  logic [ReqW-1:0]  pfreq_msg;
  logic             pfreq_val;
  logic             pfreq_rdy;
  logic [RespW-1:0] pfresp_msg;
  logic             pfresp_val;
  logic             pfresp_rdy;
  logic [ReqW-1:0]  memreq_msg;
  logic             memreq_val;
  logic             memreq_rdy;
  logic [RespW-1:0] memresp_msg;
  logic             memresp_val;
  logic             memresp_rdy;
  logic             busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [ReqW-1:0]  exp_req[$];
  logic [RespW-1:0] exp_resp[$];

  plab3_mem_prefetch_refill_queue dut (
    .clk        (clk),
    .reset      (reset),
    .domain     (domain),
    .pfreq_msg  (pfreq_msg),
    .pfreq_val  (pfreq_val),
    .pfreq_rdy  (pfreq_rdy),
    .pfresp_msg (pfresp_msg),
    .pfresp_val (pfresp_val),
    .pfresp_rdy (pfresp_rdy),
    .memreq_msg (memreq_msg),
    .memreq_val (memreq_val),
    .memreq_rdy (memreq_rdy),
    .memresp_msg(memresp_msg),
    .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ReqW-1:0] mk_req(input logic [7:0] tag, input logic [31:0] addr);
    logic [127:0] data;
    data   = {tag, 88'h0, addr};
    mk_req = {3'd0, tag, addr, 4'd0, data};
  endfunction

  function automatic logic [RespW-1:0] mk_resp(input logic [7:0] tag, input logic [127:0] data);
    mk_resp = {3'd0, tag, 2'd0, 4'd0, data};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: handshakes are sampled mid-cycle, where they predict the next rising edge
  always @(negedge clk) begin
    if (reset) begin
      if (pfreq_val && pfreq_rdy) exp_req.push_back(pfreq_msg);
      if (memreq_val && memreq_rdy) begin
        check_eq("memreq_expected", (exp_req.size() != 0), 1);
        if (exp_req.size() != 0) check_eq("memreq_msg", memreq_msg, exp_req.pop_front());
      end
      if (memresp_val && memresp_rdy) exp_resp.push_back(memresp_msg);
      if (pfresp_val && pfresp_rdy) begin
        check_eq("pfresp_expected", (exp_resp.size() != 0), 1);
        if (exp_resp.size() != 0) check_eq("pfresp_msg", pfresp_msg, exp_resp.pop_front());
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    domain      = 1'b0;
    pfreq_msg   = '0;
    pfreq_val   = 1'b0;
    pfresp_rdy  = 1'b1;
    memreq_rdy  = 1'b0;
    memresp_msg = mk_resp(8'hee, 128'h1);
    memresp_val = 1'b1;
    repeat (2) step();
    check_eq("rst_pfreq_rdy", pfreq_rdy, 0);
    check_eq("rst_memreq_val", memreq_val, 0);
    check_eq("rst_memreq_msg", memreq_msg, 0);
    check_eq("rst_memresp_rdy", memresp_rdy, 0);
    check_eq("rst_pfresp_val", pfresp_val, 0);
    check_eq("rst_pfresp_msg", pfresp_msg, 0);
    check_eq("rst_busy", busy, 0);
    memresp_val = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rw_pfreq_rdy", pfreq_rdy, 0);
    step();
    check_eq("act_pfreq_rdy", pfreq_rdy, 1);
    check_eq("act_busy", busy, 0);

    // T1: reset with three requests queued
    for (int i = 0; i < 3; i++) begin
      pfreq_val = 1'b1;
      pfreq_msg = mk_req(8'(i), 32'h40 + 32'(16 * i));
      step();
    end
    pfreq_val = 1'b0;
    #1;
    check_eq("t1_busy_pre", busy, 1);
    check_eq("t1_val_pre", memreq_val, 1);
    reset = 1'b0;
    #1;
    check_eq("t1_memreq_val", memreq_val, 0);
    check_eq("t1_memreq_msg", memreq_msg, 0);
    check_eq("t1_pfreq_rdy", pfreq_rdy, 0);
    check_eq("t1_busy", busy, 0);
    exp_req.delete();
    step();
    reset = 1'b1;
    #1;
    check_eq("t1_rw_rdy", pfreq_rdy, 0);
    step();
    check_eq("t1_rdy_after", pfreq_rdy, 1);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_fifo_cleared", memreq_val, 0);

    // T2: fill the FIFO with memory stalled, then release
    for (int i = 0; i < 4; i++) begin
      pfreq_val = 1'b1;
      pfreq_msg = mk_req(8'h10 + 8'(i), 32'h100 + 32'(16 * i));
      #1;
      check_eq("t2_accept", pfreq_rdy, 1);
      step();
    end
    pfreq_msg = mk_req(8'h14, 32'h140);
    #1;
    check_eq("t2_full_rdy", pfreq_rdy, 0);
    check_eq("t2_busy", busy, 1);
    pfreq_val  = 1'b0;
    memreq_rdy = 1'b1;
    #1;
    check_eq("t2_issue0", memreq_val, 1);
    check_eq("t2_full_fire_rdy", pfreq_rdy, 0);
    step();
    check_eq("t2_space", pfreq_rdy, 1);
    check_eq("t2_issue1", memreq_val, 1);
    step();
    check_eq("t2_limit", memreq_val, 0);

    // T3: response passthrough; simultaneous issue + response keeps the count
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h10, 128'hDEADBEEF_00000000_00000000_00000001);
    #1;
    check_eq("t3_memresp_rdy", memresp_rdy, 1);
    check_eq("t3_pfresp_val", pfresp_val, 1);
    check_eq("t3_data", pfresp_msg, mk_resp(8'h10, 128'hDEADBEEF_00000000_00000000_00000001));
    step();
    memresp_msg = mk_resp(8'h11, 128'h2);
    #1;
    check_eq("t3_both_fire", memreq_val, 1);
    step();
    memresp_val = 1'b0;
    #1;
    check_eq("t3_cnt_hold", memreq_val, 1);
    step();
    check_eq("t3_limit", memreq_val, 0);
    check_eq("t3_busy", busy, 1);

    // T5: response stalled by the prefetch buffer
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h12, 128'h3);
    pfresp_rdy  = 1'b0;
    #1;
    check_eq("t5_memresp_rdy", memresp_rdy, 0);
    check_eq("t5_pfresp_val", pfresp_val, 1);
    repeat (2) step();
    pfresp_rdy = 1'b1;
    step();
    check_eq("t5_busy_one_left", busy, 1);
    memresp_msg = mk_resp(8'h13, 128'h4);
    step();
    memresp_val = 1'b0;
    #1;
    check_eq("t5_busy_done", busy, 0);

    // Stray response with nothing outstanding: passed through, count must not underflow
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h55, 128'h5);
    #1;
    check_eq("err_passthru_val", pfresp_val, 1);
    step();
    memresp_val = 1'b0;
    #1;
    check_eq("err_no_underflow", busy, 0);

    // T4: domain change with two queued and one in flight
    memreq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pfreq_val = 1'b1;
      pfreq_msg = mk_req(8'h20 + 8'(i), 32'h300 + 32'(16 * i));
      step();
    end
    pfreq_val  = 1'b0;
    memreq_rdy = 1'b1;
    step();
    memreq_rdy = 1'b0;
    domain     = 1'b1;
    step();
    check_eq("t4_pfreq_rdy", pfreq_rdy, 0);
    check_eq("t4_busy", busy, 1);
    memreq_rdy  = 1'b1;
    memresp_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      memresp_msg = mk_resp(8'h20 + 8'(k), 128'(k));
      step();
    end
    memresp_val = 1'b0;
    #1;
    check_eq("t4_still_drain", pfreq_rdy, 0);
    check_eq("t4_busy_drain", busy, 1);
    step();
    check_eq("t4_active", pfreq_rdy, 1);
    check_eq("t4_idle", busy, 0);
    step();
    check_eq("t4_domain_q", pfreq_rdy, 1);

    // T6: request into an empty FIFO with memory ready
    pfreq_val = 1'b1;
    pfreq_msg = mk_req(8'h30, 32'h200);
    #1;
`ifdef PLAB3_MEM_PF_REFILL_BYPASS_EN
    check_eq("t6_bypass_val", memreq_val, 1);
    check_eq("t6_bypass_rdy", pfreq_rdy, 1);
    step();
    pfreq_val = 1'b0;
    #1;
    check_eq("t6_fifo_empty", memreq_val, 0);
    check_eq("t6_busy", busy, 1);
`else
    check_eq("t6_no_bypass", memreq_val, 0);
    step();
    pfreq_val = 1'b0;
    #1;
    check_eq("t6_next_cycle", memreq_val, 1);
    step();
    check_eq("t6_issued", memreq_val, 0);
    check_eq("t6_busy", busy, 1);
`endif
    memresp_val = 1'b1;
    memresp_msg = mk_resp(8'h30, 128'h6);
    step();
    memresp_val = 1'b0;
    #1;
    check_eq("t6_busy_done", busy, 0);

    step();
    check_eq("sb_req_left", exp_req.size(), 0);
    check_eq("sb_resp_left", exp_resp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
